// File: rtl/cat_trap_move_ctrl.sv
// cat_trap_move_ctrl
//   Sequences one CatTrap turn: debounces the place button, validates the
//   switch-selected cell, marks it in the BOARD_N x BOARD_N occupancy map,
//   hands the turn to the cat-move engine (req/ack) and evaluates win/lose.
//
// Optional feature macro: INIT_BLOCKS_EN
//   defined   : an INIT state after CLEAR pre-blocks INIT_BLOCKS LFSR-chosen cells
//   undefined : CLEAR goes straight to IDLE with an empty board
//
// Ports
//   board_clk, Reset        clock, asynchronous active-high reset
//   start_btn               raw place / new-game button (asynchronous)
//   row_sel, col_sel        player-selected cell
//   cat_req / cat_ack       handshake with the cat-move engine
//   cat_row, cat_col        cat's new cell, valid with cat_ack
//   cat_trapped             cat has no legal move, valid with cat_ack
//   rd_row, rd_col          display read address
//   rd_blocked              registered occupancy of the read cell (0 if out of range)
//   cur_cat_row/col         tracked cat cell
//   move_cnt                accepted player moves this game, saturating at 255
//   err_pulse               one-cycle pulse on a rejected move
//   game_over, player_won   game finished / 1 = cat trapped, 0 = cat escaped
module cat_trap_move_ctrl #(
    parameter int BOARD_N     = 11,
    parameter int DEB_CYCLES  = 1000000,
    parameter int INIT_BLOCKS = 6
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       start_btn,
    input  logic [3:0] row_sel,
    input  logic [3:0] col_sel,
    output logic       cat_req,
    input  logic       cat_ack,
    input  logic [3:0] cat_row,
    input  logic [3:0] cat_col,
    input  logic       cat_trapped,
    input  logic [3:0] rd_row,
    input  logic [3:0] rd_col,
    output logic       rd_blocked,
    output logic [3:0] cur_cat_row,
    output logic [3:0] cur_cat_col,
    output logic [7:0] move_cnt,
    output logic       err_pulse,
    output logic       game_over,
    output logic       player_won
);

    localparam int         CELLS  = BOARD_N * BOARD_N;
    localparam int         IW     = $clog2(CELLS);
    localparam int         DW     = $clog2(DEB_CYCLES + 1);
    localparam logic [3:0] CENTRE = 4'(BOARD_N / 2);
    localparam logic [3:0] LAST   = 4'(BOARD_N - 1);
    localparam logic [3:0] SIDE   = 4'(BOARD_N);

    if (BOARD_N > 15 || BOARD_N < 2 || INIT_BLOCKS < 0 || INIT_BLOCKS > 255) begin : g_param_err
        $error("cat_trap_move_ctrl: BOARD_N must be 2..15 and INIT_BLOCKS 0..255");
    end

    typedef enum logic [3:0] {
        S_CLEAR, S_INIT, S_IDLE, S_LATCH, S_CHECK,
        S_WRITE, S_CAT_REQ, S_CAT_WAIT, S_EVAL, S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_sync;
    logic [DW-1:0]   r_deb_cnt;
    logic            r_deb_fired, r_press;
    logic [CELLS-1:0] r_map;
    logic [IW-1:0]   r_clr_idx;
    logic [3:0]      r_lrow, r_lcol, r_cat_row, r_cat_col;
    logic [7:0]      r_move_cnt;
    logic            r_won, r_rd;
    logic            w_err, w_cat_req;

    function automatic logic [IW-1:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
        return IW'(r) * IW'(BOARD_N) + IW'(c);
    endfunction

    // Latched-cell validation
    logic          w_lat_in, w_lat_blocked, w_lat_is_cat, w_reject, w_cat_edge, w_rd_in;
    logic [IW-1:0] w_lat_idx;
    assign w_lat_in      = (r_lrow < SIDE) && (r_lcol < SIDE);
    assign w_lat_idx     = cell_idx(r_lrow, r_lcol);
    assign w_lat_blocked = r_map[w_lat_idx];
    assign w_lat_is_cat  = (r_lrow == r_cat_row) && (r_lcol == r_cat_col);
    // Out-of-range is tested first so the map is never trusted for a bad index
    assign w_reject      = !w_lat_in || w_lat_blocked || w_lat_is_cat;
    assign w_cat_edge    = (r_cat_row == 4'd0) || (r_cat_row == LAST) ||
                           (r_cat_col == 4'd0) || (r_cat_col == LAST);
    assign w_rd_in       = (rd_row < SIDE) && (rd_col < SIDE);

`ifdef INIT_BLOCKS_EN
    logic [15:0] r_lfsr;
    logic [7:0]  r_init_cnt;
    logic [3:0]  w_init_row, w_init_col;
    logic [IW-1:0] w_init_idx;
    logic        w_init_ok;
    assign w_init_row = r_lfsr[3:0] % SIDE;
    assign w_init_col = r_lfsr[7:4] % SIDE;
    assign w_init_idx = cell_idx(w_init_row, w_init_col);
    assign w_init_ok  = !r_map[w_init_idx] &&
                        !((w_init_row == r_cat_row) && (w_init_col == r_cat_col));
`endif

    // Button: 2-FF synchronizer + hold counter; one event per high period
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_sync      <= '0;
            r_deb_cnt   <= '0;
            r_deb_fired <= 1'b0;
            r_press     <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], start_btn};
            r_press <= 1'b0;
            if (!r_sync[1]) begin
                r_deb_cnt   <= '0;
                r_deb_fired <= 1'b0;
            end else if (!r_deb_fired) begin
                if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
                    r_press     <= 1'b1;
                    r_deb_fired <= 1'b1;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) r_state <= S_CLEAR;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_err     = 1'b0;
        w_cat_req = 1'b0;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_idx == IW'(CELLS - 1)) begin
`ifdef INIT_BLOCKS_EN
                    w_next = S_INIT;
`else
                    w_next = S_IDLE;
`endif
                end
            end
`ifdef INIT_BLOCKS_EN
            S_INIT:     if (r_init_cnt == 8'(INIT_BLOCKS)) w_next = S_IDLE;
`endif
            S_IDLE:     if (r_press) w_next = S_LATCH;
            S_LATCH:    w_next = S_CHECK;
            S_CHECK: begin
                if (w_reject) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE:    w_next = S_CAT_REQ;
            S_CAT_REQ: begin
                w_cat_req = 1'b1;
                w_next    = S_CAT_WAIT;
            end
            S_CAT_WAIT: begin
                w_cat_req = 1'b1;
                if (cat_ack) w_next = cat_trapped ? S_DONE : S_EVAL;
            end
            S_EVAL:     w_next = w_cat_edge ? S_DONE : S_IDLE;
            S_DONE:     if (r_press) w_next = S_CLEAR;
            default:    w_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_map      <= '0;
            r_clr_idx  <= '0;
            r_lrow     <= '0;
            r_lcol     <= '0;
            r_cat_row  <= CENTRE;
            r_cat_col  <= CENTRE;
            r_move_cnt <= '0;
            r_won      <= 1'b0;
            r_rd       <= 1'b0;
`ifdef INIT_BLOCKS_EN
            r_lfsr     <= 16'hACE1;
            r_init_cnt <= '0;
`endif
        end else begin
            // Sampled before any same-cycle write lands, so WRITE reads the old value
            r_rd <= w_rd_in ? r_map[cell_idx(rd_row, rd_col)] : 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_map[r_clr_idx] <= 1'b0;
                    r_clr_idx  <= (r_clr_idx == IW'(CELLS - 1)) ? '0 : r_clr_idx + 1'b1;
                    r_move_cnt <= '0;
                    r_cat_row  <= CENTRE;
                    r_cat_col  <= CENTRE;
                    r_won      <= 1'b0;
`ifdef INIT_BLOCKS_EN
                    r_init_cnt <= '0;
`endif
                end
`ifdef INIT_BLOCKS_EN
                S_INIT: begin
                    r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
                    if (r_init_cnt != 8'(INIT_BLOCKS) && w_init_ok) begin
                        r_map[w_init_idx] <= 1'b1;
                        r_init_cnt        <= r_init_cnt + 1'b1;
                    end
                end
`endif
                S_LATCH: begin
                    r_lrow <= row_sel;
                    r_lcol <= col_sel;
                end
                S_WRITE: begin
                    r_map[w_lat_idx] <= 1'b1;
                    if (r_move_cnt != 8'hFF) r_move_cnt <= r_move_cnt + 1'b1;
                end
                S_CAT_WAIT: begin
                    if (cat_ack) begin
                        if (cat_trapped) begin
                            r_won <= 1'b1;
                        end else begin
                            r_cat_row <= cat_row;
                            r_cat_col <= cat_col;
                        end
                    end
                end
                S_EVAL:  if (w_cat_edge) r_won <= 1'b0;
                default: ;
            endcase
        end
    end

    assign cat_req     = w_cat_req;
    assign err_pulse   = w_err;
    assign game_over   = (r_state == S_DONE);
    assign player_won  = r_won;
    assign rd_blocked  = r_rd;
    assign cur_cat_row = r_cat_row;
    assign cur_cat_col = r_cat_col;
    assign move_cnt    = r_move_cnt;

endmodule

// File: tb/tb_cat_trap_move_ctrl.sv
module tb_cat_trap_move_ctrl;
    localparam int N     = 11;
    localparam int DEB   = 4;
    localparam int CELLS = N * N;

    logic       board_clk = 1'b0;
    logic       Reset, start_btn, cat_ack, cat_trapped;
    logic [3:0] row_sel, col_sel, cat_row, cat_col, rd_row, rd_col;
    logic       cat_req, rd_blocked, err_pulse, game_over, player_won;
    logic [3:0] cur_cat_row, cur_cat_col;
    logic [7:0] move_cnt;

    cat_trap_move_ctrl #(.BOARD_N(N), .DEB_CYCLES(DEB), .INIT_BLOCKS(6)) dut (
        .board_clk(board_clk), .Reset(Reset), .start_btn(start_btn),
        .row_sel(row_sel), .col_sel(col_sel), .cat_req(cat_req), .cat_ack(cat_ack),
        .cat_row(cat_row), .cat_col(cat_col), .cat_trapped(cat_trapped),
        .rd_row(rd_row), .rd_col(rd_col), .rd_blocked(rd_blocked),
        .cur_cat_row(cur_cat_row), .cur_cat_col(cur_cat_col), .move_cnt(move_cnt),
        .err_pulse(err_pulse), .game_over(game_over), .player_won(player_won)
    );

    always #5 board_clk = ~board_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Holds the button for 'hold' clock edges; reports err pulses and first cat_req sample
    task automatic do_press(input logic [3:0] r, input logic [3:0] c, input int hold,
                            output int n_err, output int first_err, output int first_req);
        row_sel = r; col_sel = c; start_btn = 1'b1;
        n_err = 0; first_err = 0; first_req = 0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge board_clk);
            if (err_pulse) begin
                n_err++;
                if (first_err == 0) first_err = i;
            end
            if (cat_req && first_req == 0) first_req = i;
        end
        start_btn = 1'b0;
    endtask

    task automatic watch(input int n, output int n_err, output int n_req);
        n_err = 0; n_req = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge board_clk);
            if (err_pulse) n_err++;
            if (cat_req)   n_req++;
        end
    endtask

    task automatic read_cell(input logic [3:0] r, input logic [3:0] c, output int v);
        rd_row = r; rd_col = c;
        @(negedge board_clk);
        v = int'(rd_blocked);
    endtask

    task automatic do_ack(input logic [3:0] r, input logic [3:0] c, input logic trap);
        cat_ack = 1'b1; cat_row = r; cat_col = c; cat_trapped = trap;
        @(negedge board_clk);
        cat_ack = 1'b0; cat_trapped = 1'b0;
        chk("req_drop_after_ack", int'(cat_req), 0);
        repeat (2) @(negedge board_clk);
    endtask

    typedef struct {
        logic [3:0] row, col;
        bit         valid;
        logic [3:0] cr, cc;
        bit         trap;
        int         exp_cnt;
        int         exp_over, exp_won, exp_cell;
        int         exp_crow, exp_ccol;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int ne, fe, fr, nr, v;

        vecs[0] = '{4'd2,  4'd3,  1'b1, 4'd5, 4'd4, 1'b0, 1, 0, 0, 1, 5, 4};
        vecs[1] = '{4'd2,  4'd3,  1'b0, 4'd0, 4'd0, 1'b0, 1, 0, 0, 1, 5, 4};
        vecs[2] = '{4'd12, 4'd0,  1'b0, 4'd0, 4'd0, 1'b0, 1, 0, 0, 0, 5, 4};
        vecs[3] = '{4'd5,  4'd4,  1'b0, 4'd0, 4'd0, 1'b0, 1, 0, 0, 0, 5, 4};
        vecs[4] = '{4'd5,  4'd5,  1'b1, 4'd4, 4'd4, 1'b0, 2, 0, 0, 1, 4, 4};
        vecs[5] = '{4'd10, 4'd10, 1'b1, 4'd3, 4'd4, 1'b0, 3, 0, 0, 1, 3, 4};
        vecs[6] = '{4'd0,  4'd11, 1'b0, 4'd0, 4'd0, 1'b0, 3, 0, 0, 0, 3, 4};
        vecs[7] = '{4'd1,  4'd1,  1'b1, 4'd0, 4'd4, 1'b0, 4, 1, 0, 1, 0, 4};

        Reset = 1'b1; start_btn = 1'b0; cat_ack = 1'b0; cat_trapped = 1'b0;
        row_sel = '0; col_sel = '0; cat_row = '0; cat_col = '0; rd_row = '0; rd_col = '0;
        repeat (2) @(negedge board_clk);
        chk("rst_cat_req",  int'(cat_req), 0);
        chk("rst_move_cnt", int'(move_cnt), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_err",      int'(err_pulse), 0);
        chk("rst_cat_row",  int'(cur_cat_row), 5);
        chk("rst_cat_col",  int'(cur_cat_col), 5);
        Reset = 1'b0;
        repeat (CELLS + 5) @(negedge board_clk);
        read_cell(4'd2, 4'd3, v);
        chk("rst_cell_2_3", v, 0);

        // Table: one turn per record
        for (int i = 0; i < 8; i++) begin
            do_press(vecs[i].row, vecs[i].col, DEB + 12, ne, fe, fr);
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_req_latency", i), fr, DEB + 6);
                chk($sformatf("v%0d_no_err", i), ne, 0);
                do_ack(vecs[i].cr, vecs[i].cc, vecs[i].trap);
            end else begin
                chk($sformatf("v%0d_err_count", i), ne, 1);
                chk($sformatf("v%0d_err_time", i), fe, DEB + 4);
                chk($sformatf("v%0d_no_req", i), fr, 0);
            end
            repeat (3) @(negedge board_clk);
            chk($sformatf("v%0d_move_cnt", i), int'(move_cnt), vecs[i].exp_cnt);
            chk($sformatf("v%0d_game_over", i), int'(game_over), vecs[i].exp_over);
            if (vecs[i].exp_over != 0)
                chk($sformatf("v%0d_player_won", i), int'(player_won), vecs[i].exp_won);
            chk($sformatf("v%0d_cat_row", i), int'(cur_cat_row), vecs[i].exp_crow);
            chk($sformatf("v%0d_cat_col", i), int'(cur_cat_col), vecs[i].exp_ccol);
            read_cell(vecs[i].row, vecs[i].col, v);
            chk($sformatf("v%0d_cell", i), v, vecs[i].exp_cell);
        end

        // New game from DONE, then the cat cell (5,5) is rejected
        do_press(4'd0, 4'd0, DEB + 12, ne, fe, fr);
        repeat (CELLS + 5) @(negedge board_clk);
        chk("new_game_over", int'(game_over), 0);
        chk("new_move_cnt",  int'(move_cnt), 0);
        chk("new_cat_row",   int'(cur_cat_row), 5);
        chk("new_cat_col",   int'(cur_cat_col), 5);
        read_cell(4'd2, 4'd3, v);
        chk("new_cell_2_3_cleared", v, 0);
        read_cell(4'd10, 4'd10, v);
        chk("new_cell_10_10_cleared", v, 0);
        do_press(4'd5, 4'd5, DEB + 12, ne, fe, fr);
        chk("catcell_err", ne, 1);
        chk("catcell_no_req", fr, 0);
        watch(4, ne, nr);
        read_cell(4'd5, 4'd5, v);
        chk("catcell_cell", v, 0);

        // Press during CAT_WAIT is discarded; then trapped -> player wins
        do_press(4'd7, 4'd7, DEB + 12, ne, fe, fr);
        chk("b_req_latency", fr, DEB + 6);
        watch(4, ne, nr);
        do_press(4'd8, 4'd8, DEB + 12, ne, fe, fr);
        chk("b_wait_no_err", ne, 0);
        chk("b_req_held", int'(cat_req), 1);
        chk("b_move_cnt_wait", int'(move_cnt), 1);
        watch(4, ne, nr);
        do_ack(4'd0, 4'd0, 1'b1);
        chk("b_game_over", int'(game_over), 1);
        chk("b_player_won", int'(player_won), 1);
        chk("b_move_cnt", int'(move_cnt), 1);
        chk("b_cat_row", int'(cur_cat_row), 5);
        read_cell(4'd8, 4'd8, v);
        chk("b_cell_8_8", v, 0);
        read_cell(4'd7, 4'd7, v);
        chk("b_cell_7_7", v, 1);

        // New game; short glitch, stray ack, then one long hold
        do_press(4'd0, 4'd0, DEB + 12, ne, fe, fr);
        repeat (CELLS + 5) @(negedge board_clk);
        chk("c_game_over", int'(game_over), 0);
        do_press(4'd3, 4'd3, DEB - 1, ne, fe, fr);
        watch(20, ne, nr);
        chk("glitch_no_err", ne, 0);
        chk("glitch_no_req", nr + fr, 0);
        chk("glitch_move_cnt", int'(move_cnt), 0);
        read_cell(4'd3, 4'd3, v);
        chk("glitch_cell", v, 0);
        cat_ack = 1'b1; cat_row = 4'd0; cat_col = 4'd0; cat_trapped = 1'b1;
        @(negedge board_clk);
        cat_ack = 1'b0; cat_trapped = 1'b0;
        repeat (3) @(negedge board_clk);
        chk("stray_ack_over", int'(game_over), 0);
        chk("stray_ack_cat_row", int'(cur_cat_row), 5);
        do_press(4'd3, 4'd3, 3 * DEB, ne, fe, fr);
        chk("long_req_latency", fr, DEB + 6);
        do_ack(4'd4, 4'd5, 1'b0);
        watch(3 * DEB + 4, ne, nr);
        chk("long_single_req", nr, 0);
        chk("long_move_cnt", int'(move_cnt), 1);
        chk("long_cat_col", int'(cur_cat_col), 5);
        read_cell(4'd3, 4'd3, v);
        chk("long_cell", v, 1);

        // Asynchronous reset while waiting on the cat engine
        do_press(4'd6, 4'd6, DEB + 12, ne, fe, fr);
        chk("d_req_up", int'(cat_req), 1);
        #2 Reset = 1'b1;
        #1;
        chk("d_req_drop_async", int'(cat_req), 0);
        chk("d_move_cnt", int'(move_cnt), 0);
        chk("d_cat_row", int'(cur_cat_row), 5);
        @(negedge board_clk);
        Reset = 1'b0;
        repeat (CELLS + 5) @(negedge board_clk);
        chk("d_after_over", int'(game_over), 0);
        chk("d_after_req", int'(cat_req), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
